// File: rtl/rgb_pwm_engine.sv
// Alarm-driven multi-LED RGB PWM engine: off, colour-wheel fade (ACTIVE) and red blink (WAKE).
// Define RGB_PHASE_STAGGER_EN to offset each LED's fade phase, giving a rotating rainbow.
module rgb_pwm_engine #(
   parameter int         NUM_LEDS          = 2,
   parameter int         PWM_BITS          = 8,
   parameter int         MAX_BRIGHTNESS    = 4,
   parameter int         BLINK_LEVEL       = (2 ** PWM_BITS) - 1,
   parameter int         FADE_STEP_CYCLES  = 1_000_000,
   parameter int         BLINK_HALF_CYCLES = 50_000_000,
   parameter logic [3:0] ALARM_IDLE_MODE   = 4'b1000,
   parameter logic [3:0] ALARM_ACTIVE_MODE = 4'b1001,
   parameter logic [3:0] ALARM_WAKE_MODE   = 4'b1010
) (
   input  logic                  GCLK,
   input  logic                  RST_N,
   input  logic [3:0]            alarm_state_in,
   output logic [3*NUM_LEDS-1:0] RGB_LED_O
);
   localparam int SEG     = 2 ** (PWM_BITS - 1);
   localparam int PH_W    = PWM_BITS + 1;
   localparam int STEP_W  = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
   localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
`ifdef RGB_PHASE_STAGGER_EN
   localparam int STAGGER = (3 * SEG) / NUM_LEDS;
`else
   localparam int STAGGER = 0;
`endif
   localparam logic [PH_W-1:0]     PHASE_LAST = PH_W'(3 * SEG - 1);
   localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(FADE_STEP_CYCLES - 1);
   localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] ZERO       = {PWM_BITS{1'b0}};
   localparam logic [PWM_BITS-1:0] BLINK_LV   = PWM_BITS'(BLINK_LEVEL);
   localparam logic [PWM_BITS-1:0] MAX_B      = (MAX_BRIGHTNESS >= (2 ** PWM_BITS) - 1) ?
                                                {PWM_BITS{1'b1}} : PWM_BITS'(MAX_BRIGHTNESS);

   logic [3:0]            mode_q, mode_d;
   logic [PWM_BITS-1:0]   win_q, win_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [PH_W-1:0]       phase_q, phase_d;
   logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                  blink_on_q, blink_on_d;
   logic [3*NUM_LEDS-1:0] rgb_q, rgb_d;
   logic                  enter_active_s, enter_wake_s;

   function automatic logic [PWM_BITS-1:0] clamp_term(input logic [PWM_BITS-1:0] t);
      clamp_term = (t > MAX_B) ? MAX_B : t;
   endfunction

   // Within a segment, dec is just the bitwise complement of inc.
   function automatic logic [3*PWM_BITS-1:0] fade_rgb(input logic [PH_W-1:0] p);
      logic [PWM_BITS-1:0] inc;
      logic [PWM_BITS-1:0] dec;
      inc = {1'b0, p[PWM_BITS-2:0]};
      dec = {1'b0, ~p[PWM_BITS-2:0]};
      case (p[PH_W-1:PWM_BITS-1])
         2'd0:    fade_rgb = {clamp_term(inc), clamp_term(dec), ZERO};
         2'd1:    fade_rgb = {clamp_term(dec), ZERO, clamp_term(inc)};
         2'd2:    fade_rgb = {ZERO, clamp_term(inc), clamp_term(dec)};
         default: fade_rgb = {3{ZERO}};
      endcase
   endfunction

   function automatic logic [PH_W-1:0] led_phase(input logic [PH_W-1:0] p, input int k);
      logic [PH_W:0] sum;
      sum = {1'b0, p} + (PH_W+1)'(k * STAGGER);
      if (sum > {1'b0, PHASE_LAST}) begin
         sum = sum - (PH_W+1)'(3 * SEG);
      end else begin
         sum = sum;
      end
      led_phase = sum[PH_W-1:0];
   endfunction

   // Next state of the mode register, PWM window and the fade/blink timebases.
   always_comb begin
      mode_d         = alarm_state_in;
      win_d          = win_q + PWM_BITS'(1);
      enter_active_s = (alarm_state_in == ALARM_ACTIVE_MODE) && (mode_q != ALARM_ACTIVE_MODE);
      enter_wake_s   = (alarm_state_in == ALARM_WAKE_MODE) && (mode_q != ALARM_WAKE_MODE);

      if (enter_active_s) begin
         step_d  = {STEP_W{1'b0}};
         phase_d = {PH_W{1'b0}};
      end else if (mode_q == ALARM_ACTIVE_MODE) begin
         if (step_q == STEP_LAST) begin
            step_d  = {STEP_W{1'b0}};
            phase_d = (phase_q == PHASE_LAST) ? {PH_W{1'b0}} : phase_q + PH_W'(1);
         end else begin
            step_d  = step_q + STEP_W'(1);
            phase_d = phase_q;
         end
      end else begin
         step_d  = step_q;
         phase_d = phase_q;
      end

      if (enter_wake_s) begin
         blink_cnt_d = {BLINK_W{1'b0}};
         blink_on_d  = 1'b1;
      end else if (mode_q == ALARM_WAKE_MODE) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = {BLINK_W{1'b0}};
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            blink_on_d  = blink_on_q;
         end
      end else begin
         blink_cnt_d = blink_cnt_q;
         blink_on_d  = blink_on_q;
      end
   end

   // Per-LED channel values compared against the shared PWM window.
   always_comb begin
      logic [3*PWM_BITS-1:0] chan;
      chan  = {3{ZERO}};
      rgb_d = {(3*NUM_LEDS){1'b0}};
      for (int k = 0; k < NUM_LEDS; k++) begin
         if (mode_q == ALARM_ACTIVE_MODE) begin
            chan = fade_rgb(led_phase(phase_q, k));
         end else if (mode_q == ALARM_WAKE_MODE) begin
            chan = {(blink_on_q ? BLINK_LV : ZERO), ZERO, ZERO};
         end else begin
            chan = {3{ZERO}};
         end
         rgb_d[3*k+2] = chan[3*PWM_BITS-1 -: PWM_BITS] > win_q;
         rgb_d[3*k+1] = chan[2*PWM_BITS-1 -: PWM_BITS] > win_q;
         rgb_d[3*k]   = chan[PWM_BITS-1 -: PWM_BITS] > win_q;
      end
   end

   // State and output registers; reset darkens the pins without needing a clock.
   always_ff @(posedge GCLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_q      <= ALARM_IDLE_MODE;
         win_q       <= {PWM_BITS{1'b0}};
         step_q      <= {STEP_W{1'b0}};
         phase_q     <= {PH_W{1'b0}};
         blink_cnt_q <= {BLINK_W{1'b0}};
         blink_on_q  <= 1'b0;
         rgb_q       <= {(3*NUM_LEDS){1'b0}};
      end else begin
         mode_q      <= mode_d;
         win_q       <= win_d;
         step_q      <= step_d;
         phase_q     <= phase_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         rgb_q       <= rgb_d;
      end
   end

   assign RGB_LED_O = rgb_q;

endmodule
